// File: rtl/vga_pkg.sv
// Shared definitions for the VGA SRAM arbiter: FSM state encoding and
// requester port indices (grant vectors are ordered {W,R,V}).
package vga_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GNT_V = 2'd1,
      ARB_GNT_R = 2'd2,
      ARB_GNT_W = 2'd3
   } arb_state_t;

   localparam int PORT_V  = 0;
   localparam int PORT_R  = 1;
   localparam int PORT_W  = 2;
   localparam int N_PORTS = 3;

endpackage

// File: rtl/vga_arb_pick.sv
// Combinational winner selection for one SRAM transfer: video first unless the
// CPU has been held off VID_MAX times; R/W tie broken by the round-robin bit.
module vga_arb_pick (
   input  logic [2:0] stb,
   input  logic       vid_max,
   input  logic       rr,
   output logic [2:0] win
);
   import vga_pkg::*;

   logic       cpu_req;
   logic [2:0] cpu_win;

   assign cpu_req = stb[PORT_R] | stb[PORT_W];

   // rr == 0 prefers R, rr == 1 prefers W; a lone requester always wins
   always_comb begin
      cpu_win = '0;
      if (stb[PORT_R] && (!stb[PORT_W] || !rr)) begin
         cpu_win[PORT_R] = 1'b1;
      end else if (stb[PORT_W]) begin
         cpu_win[PORT_W] = 1'b1;
      end
   end

   always_comb begin
      win = '0;
      if (cpu_req && vid_max) begin
         win = cpu_win;
      end else if (stb[PORT_V]) begin
         win[PORT_V] = 1'b1;
      end else begin
         win = cpu_win;
      end
   end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Per-transfer arbiter sharing the SRAM Wishbone master among video fetch,
// CPU read and CPU write; one grant per access, always followed by an IDLE cycle.
module vga_mem_arbiter #(
   parameter int VID_MAX = 4,
   parameter int CNT_W   = 3
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [17:1] v_adr_i,
   input  logic        v_stb_i,
   output logic [15:0] v_dat_o,
   output logic        v_ack_o,
   input  logic [17:1] r_adr_i,
   input  logic        r_stb_i,
   output logic [15:0] r_dat_o,
   output logic        r_ack_o,
   input  logic [17:1] w_adr_i,
   input  logic [15:0] w_dat_i,
   input  logic [1:0]  w_sel_i,
   input  logic        w_stb_i,
   output logic        w_ack_o,
   output logic [17:1] m_adr_o,
   output logic [15:0] m_dat_o,
   input  logic [15:0] m_dat_i,
   output logic [1:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_stb_o,
   input  logic        m_ack_i,
   output logic [2:0]  gnt_o
);
   import vga_pkg::*;

   localparam logic [CNT_W-1:0] VID_MAX_C = CNT_W'(VID_MAX);

   arb_state_t       state;
   logic [CNT_W-1:0] vid_cnt;
   logic             rr;
   logic             cpu_at_gnt;
   logic             cnt_max;
   logic [2:0]       stbs;
   logic [2:0]       win;

   assign stbs    = {w_stb_i, r_stb_i, v_stb_i};
   assign cnt_max = (vid_cnt == VID_MAX_C);

   vga_arb_pick u_pick (
      .stb     (stbs),
      .vid_max (cnt_max),
      .rr      (rr),
      .win     (win)
   );

   // cpu_at_gnt remembers whether the CPU was waiting when video won, so the
   // starvation counter only advances for video grants that actually held it off
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= ARB_IDLE;
         vid_cnt    <= '0;
         rr         <= 1'b0;
         cpu_at_gnt <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (win[PORT_V]) begin
                  state      <= ARB_GNT_V;
                  cpu_at_gnt <= r_stb_i | w_stb_i;
               end else if (win[PORT_R]) begin
                  state <= ARB_GNT_R;
               end else if (win[PORT_W]) begin
                  state <= ARB_GNT_W;
               end
            end
            ARB_GNT_V: begin
               if (m_ack_i) begin
                  state <= ARB_IDLE;
                  if (!cpu_at_gnt) begin
                     vid_cnt <= '0;
                  end else if (!cnt_max) begin
                     vid_cnt <= vid_cnt + 1'b1;
                  end
               end
            end
            ARB_GNT_R: begin
               if (m_ack_i) begin
                  state   <= ARB_IDLE;
                  vid_cnt <= '0;
                  rr      <= 1'b1;
               end
            end
            ARB_GNT_W: begin
               if (m_ack_i) begin
                  state   <= ARB_IDLE;
                  vid_cnt <= '0;
                  rr      <= 1'b0;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // master port mux; IDLE drives address/strobe low
   always_comb begin
      m_adr_o = '0;
      m_stb_o = 1'b0;
      m_we_o  = 1'b0;
      m_sel_o = 2'b11;
      gnt_o   = '0;
      case (state)
         ARB_GNT_V: begin
            m_adr_o       = v_adr_i;
            m_stb_o       = v_stb_i;
            gnt_o[PORT_V] = 1'b1;
         end
         ARB_GNT_R: begin
            m_adr_o       = r_adr_i;
            m_stb_o       = r_stb_i;
            gnt_o[PORT_R] = 1'b1;
         end
         ARB_GNT_W: begin
            m_adr_o       = w_adr_i;
            m_stb_o       = w_stb_i;
            m_we_o        = 1'b1;
            m_sel_o       = w_sel_i;
            gnt_o[PORT_W] = 1'b1;
         end
         default: ;
      endcase
   end

   assign m_dat_o = w_dat_i;
   assign v_dat_o = m_dat_i;
   assign r_dat_o = m_dat_i;
   assign v_ack_o = m_ack_i & (state == ARB_GNT_V);
   assign r_ack_o = m_ack_i & (state == ARB_GNT_R);
   assign w_ack_o = m_ack_i & (state == ARB_GNT_W);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: transaction-level model of grant order, directed
// scenarios with literal expectations, and a randomized traffic run.
module tb_vga_mem_arbiter;

   localparam int VID_MAX = 4;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic [2:0]  stb;
   logic [17:1] adr [3];
   logic [15:0] w_dat;
   logic [1:0]  w_sel;
   logic        m_ack_i;
   logic [15:0] m_dat_i;

   logic [15:0] v_dat_o, r_dat_o, m_dat_o;
   logic        v_ack_o, r_ack_o, w_ack_o;
   logic [17:1] m_adr_o;
   logic [1:0]  m_sel_o;
   logic        m_we_o, m_stb_o;
   logic [2:0]  gnt_o;

   vga_mem_arbiter #(.VID_MAX(VID_MAX), .CNT_W(3)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .v_adr_i  (adr[0]),
      .v_stb_i  (stb[0]),
      .v_dat_o  (v_dat_o),
      .v_ack_o  (v_ack_o),
      .r_adr_i  (adr[1]),
      .r_stb_i  (stb[1]),
      .r_dat_o  (r_dat_o),
      .r_ack_o  (r_ack_o),
      .w_adr_i  (adr[2]),
      .w_dat_i  (w_dat),
      .w_sel_i  (w_sel),
      .w_stb_i  (stb[2]),
      .w_ack_o  (w_ack_o),
      .m_adr_o  (m_adr_o),
      .m_dat_o  (m_dat_o),
      .m_dat_i  (m_dat_i),
      .m_sel_o  (m_sel_o),
      .m_we_o   (m_we_o),
      .m_stb_o  (m_stb_o),
      .m_ack_i  (m_ack_i),
      .gnt_o    (gnt_o)
   );

   // clock / reset
   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---- reference model: who owns the SRAM, and how long the CPU was held off
   int mg;            // owner port index, -1 when nobody owns it
   int streak;        // video transfers served while the CPU was waiting
   bit pref_w;        // next R/W tie goes to W
   bit cpu_waiting;   // CPU request present when video was handed the port

   function automatic int cpu_choice(input bit r, input bit w, input bit pw);
      if (r && w) return pw ? 2 : 1;
      return r ? 1 : 2;
   endfunction

   always @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         mg <= -1; streak <= 0; pref_w <= 1'b0; cpu_waiting <= 1'b0;
      end else if (mg < 0) begin
         if ((stb[1] || stb[2]) && (streak == VID_MAX || !stb[0])) begin
            mg <= cpu_choice(stb[1], stb[2], pref_w);
         end else if (stb[0]) begin
            mg <= 0;
            cpu_waiting <= stb[1] || stb[2];
         end
      end else if (m_ack_i) begin
         if (mg == 0) begin
            streak <= cpu_waiting ? ((streak < VID_MAX) ? streak + 1 : VID_MAX) : 0;
         end else begin
            streak <= 0;
            pref_w <= (mg == 1);
         end
         mg <= -1;
      end
   end

   // ---- scoreboard state
   int n_tests = 0;
   int n_fail  = 0;
   int seq_q[$];      // order in which transfers were acknowledged
   logic [2:0] ack_seen;
   int wait_c [3];
   int max_wait;

   // ---- stimulus controls
   bit   auto_sram, auto_req, hold, sel_rand;
   logic [2:0] req_en;
   logic [1:0] sel_fix;
   int   max_lat, sram_wait;
   bit   sram_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_stb(input int p);
      case (p)
         0: return stb[0];
         1: return stb[1];
         2: return stb[2];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [17:1] model_adr(input int p);
      case (p)
         0: return adr[0];
         1: return adr[1];
         2: return adr[2];
         default: return '0;
      endcase
   endfunction

   task automatic new_req(input int p);
      case (p)
         0: begin stb[0] = 1'b1; adr[0] = 17'($urandom); end
         1: begin stb[1] = 1'b1; adr[1] = 17'($urandom); end
         default: begin
            stb[2] = 1'b1; adr[2] = 17'($urandom); w_dat = 16'($urandom);
            w_sel  = sel_rand ? 2'($urandom_range(0, 3)) : sel_fix;
         end
      endcase
   endtask

   task automatic req_drive();
      for (int p = 0; p < 3; p++) begin
         if (!req_en[p]) begin
            stb[p] = 1'b0;
         end else if (stb[p]) begin
            if (ack_seen[p]) begin
               if (hold || $urandom_range(0, 1) == 1) new_req(p);
               else stb[p] = 1'b0;
            end
         end else if (hold || $urandom_range(0, 2) == 0) begin
            new_req(p);
         end
      end
   endtask

   task automatic sram_drive();
      if (m_ack_i) begin
         m_ack_i = 1'b0;
      end else if (m_stb_o) begin
         if (!sram_busy) begin
            sram_busy = 1'b1;
            sram_wait = $urandom_range(0, max_lat);
         end
         if (sram_wait == 0) begin
            m_ack_i   = 1'b1;
            m_dat_i   = 16'($urandom);
            sram_busy = 1'b0;
         end else begin
            sram_wait--;
         end
      end else begin
         sram_busy = 1'b0;
      end
   endtask

   // inputs change 1 ns after the rising edge
   task automatic edge_go();
      @(posedge wb_clk_i);
      #1;
      if (auto_sram) sram_drive();
      if (auto_req)  req_drive();
   endtask

   // outputs are compared with the model on the falling edge
   task automatic sample();
      @(negedge wb_clk_i);
      chk("gnt_o",   gnt_o,   (mg < 0) ? 3'b000 : 3'(1 << mg));
      chk("m_stb_o", m_stb_o, model_stb(mg));
      chk("m_adr_o", m_adr_o, model_adr(mg));
      chk("m_we_o",  m_we_o,  mg == 2);
      chk("m_sel_o", m_sel_o, (mg == 2) ? w_sel : 2'b11);
      chk("m_dat_o", m_dat_o, w_dat);
      chk("v_ack_o", v_ack_o, m_ack_i && mg == 0);
      chk("r_ack_o", r_ack_o, m_ack_i && mg == 1);
      chk("w_ack_o", w_ack_o, m_ack_i && mg == 2);
      chk("v_dat_o", v_dat_o, m_dat_i);
      chk("r_dat_o", r_dat_o, m_dat_i);
      if (mg >= 0) chk("stb_held_until_ack", model_stb(mg), 1'b1);
      ack_seen = {w_ack_o, r_ack_o, v_ack_o};
      for (int p = 0; p < 3; p++) begin
         if (ack_seen[p]) seq_q.push_back(p);
         if (stb[p] && !ack_seen[p]) wait_c[p]++;
         else wait_c[p] = 0;
         if (wait_c[p] > max_wait) max_wait = wait_c[p];
      end
   endtask

   task automatic cycle();
      edge_go();
      sample();
   endtask

   task automatic do_reset();
      auto_sram = 1'b0; auto_req = 1'b0;
      edge_go();
      wb_rst_i = 1'b1; stb = '0; m_ack_i = 1'b0; sram_busy = 1'b0;
      sample();
      edge_go();
      sample();
      chk("rst_gnt",   gnt_o,   3'b000);
      chk("rst_m_stb", m_stb_o, 1'b0);
      chk("rst_m_we",  m_we_o,  1'b0);
      chk("rst_m_adr", m_adr_o, 17'h0);
      chk("rst_acks",  {w_ack_o, r_ack_o, v_ack_o}, 3'b000);
      edge_go();
      wb_rst_i = 1'b0;
      sample();
      chk("post_rst_gnt",   gnt_o,   3'b000);
      chk("post_rst_m_stb", m_stb_o, 1'b0);
      seq_q.delete();
      ack_seen = '0;
      for (int p = 0; p < 3; p++) wait_c[p] = 0;
   endtask

   initial begin
      wb_rst_i = 1'b1; stb = '0; w_dat = '0; w_sel = '0; m_ack_i = 1'b0; m_dat_i = '0;
      for (int p = 0; p < 3; p++) adr[p] = '0;
      auto_sram = 1'b0; auto_req = 1'b0; hold = 1'b0; sel_rand = 1'b1;
      req_en = '0; sel_fix = 2'b11; max_lat = 0; sram_wait = 0; sram_busy = 1'b0;
      ack_seen = '0; max_wait = 0;

      // single CPU read, SRAM answers two cycles after the strobe
      do_reset();
      edge_go(); stb[1] = 1'b1; adr[1] = 17'h00010; sample();
      edge_go(); sample();
      chk("rd_m_stb", m_stb_o, 1'b1);
      chk("rd_gnt",   gnt_o,   3'b010);
      chk("rd_m_adr", m_adr_o, 17'h00010);
      chk("rd_m_sel", m_sel_o, 2'b11);
      edge_go(); sample();
      chk("rd_no_early_ack", r_ack_o, 1'b0);
      edge_go(); m_ack_i = 1'b1; m_dat_i = 16'hBEEF; sample();
      chk("rd_ack",   r_ack_o, 1'b1);
      chk("rd_dat",   r_dat_o, 16'hBEEF);
      chk("rd_other_acks", {w_ack_o, v_ack_o}, 2'b00);
      edge_go(); m_ack_i = 1'b0; stb[1] = 1'b0; sample();
      chk("rd_gnt_after", gnt_o, 3'b000);
      edge_go(); sample();
      chk("rd_one_ack", seq_q.size(), 1);

      // write byte selects and data, then a read showing read-side controls
      do_reset();
      edge_go(); stb[2] = 1'b1; adr[2] = 17'h1ABCD; w_sel = 2'b01; w_dat = 16'h1234; sample();
      edge_go(); sample();
      chk("wr_gnt",   gnt_o,   3'b100);
      chk("wr_m_we",  m_we_o,  1'b1);
      chk("wr_m_sel", m_sel_o, 2'b01);
      chk("wr_m_dat", m_dat_o, 16'h1234);
      edge_go(); m_ack_i = 1'b1; sample();
      chk("wr_ack", w_ack_o, 1'b1);
      edge_go(); m_ack_i = 1'b0; stb[2] = 1'b0; stb[1] = 1'b1; adr[1] = 17'h00777; sample();
      chk("wr_idle_gap", gnt_o, 3'b000);
      edge_go(); sample();
      chk("rd2_gnt",   gnt_o,   3'b010);
      chk("rd2_m_we",  m_we_o,  1'b0);
      chk("rd2_m_sel", m_sel_o, 2'b11);
      edge_go(); m_ack_i = 1'b1; sample();
      edge_go(); m_ack_i = 1'b0; stb[1] = 1'b0; sample();

      // reset while video holds the port with the SRAM ack outstanding
      do_reset();
      edge_go(); stb[0] = 1'b1; adr[0] = 17'h00100; sample();
      edge_go(); sample();
      chk("rstv_gnt_before", gnt_o, 3'b001);
      edge_go(); wb_rst_i = 1'b1; sample();
      edge_go(); wb_rst_i = 1'b0; stb[0] = 1'b0; m_ack_i = 1'b1; sample();
      chk("rstv_m_stb",    m_stb_o, 1'b0);
      chk("rstv_gnt",      gnt_o,   3'b000);
      chk("rstv_late_ack", v_ack_o, 1'b0);
      edge_go(); m_ack_i = 1'b0; sample();

      // stray SRAM ack with nobody granted
      edge_go(); m_ack_i = 1'b1; sample();
      chk("stray_acks", {w_ack_o, r_ack_o, v_ack_o}, 3'b000);
      edge_go(); m_ack_i = 1'b0; sample();
      chk("stray_idle", gnt_o, 3'b000);

      // video and CPU read both held, single-cycle SRAM
      do_reset();
      req_en = 3'b011; hold = 1'b1; max_lat = 0; auto_sram = 1'b1; auto_req = 1'b1;
      repeat (30) cycle();
      chk("vid_order_len", seq_q.size() >= 10, 1'b1);
      for (int i = 0; i < 10 && i < seq_q.size(); i++)
         chk("vid_order", seq_q[i], (i % 5 == 4) ? 1 : 0);

      // read and write both held, no video
      do_reset();
      req_en = 3'b110; hold = 1'b1; sel_rand = 1'b0; sel_fix = 2'b10;
      auto_sram = 1'b1; auto_req = 1'b1;
      repeat (20) cycle();
      chk("rw_order_len", seq_q.size() >= 6, 1'b1);
      for (int i = 0; i < 6 && i < seq_q.size(); i++)
         chk("rw_order", seq_q[i], (i % 2 == 0) ? 1 : 2);

      // randomized traffic on all ports with variable SRAM latency
      do_reset();
      req_en = 3'b111; hold = 1'b0; sel_rand = 1'b1; max_lat = 3; max_wait = 0;
      auto_sram = 1'b1; auto_req = 1'b1;
      repeat (4000) cycle();
      chk("rand_acks_seen", seq_q.size() > 200, 1'b1);
      chk("rand_wait_bound", max_wait <= 64, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
